// File: rtl/nco_pkg.sv
// Shared widths and FSM encoding for the NCO step front-end.
package nco_pkg;

  localparam int PHASE_W    = 32;
  localparam int SW_W       = 10;
  localparam int STEP_SHIFT = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } slew_state_e;

endpackage

// File: rtl/nco_step_ctrl_sw_debounce.sv
// Switch-bank front end: 2-flop synchronizer followed by a debounce filter.
// A value is accepted only after it has been seen on the synchronized bus
// for DEBOUNCE_CYCLES+1 consecutive clocks.
module sw_debounce
  import nco_pkg::*;
#(
  parameter int WIDTH           = SW_W,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw_stable
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  // Two-stage synchronizer; the only logic that sees the raw switches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Candidate/counter filter; the stable value is published as the count reaches its limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_ONE;
      if (r_cnt == CNT_LAST) begin
        r_stable <= r_cand;
      end
    end
  end

  assign o_sw_stable = r_stable;

endmodule

// File: rtl/nco_step_ctrl.sv
// Phase-step front end for the NCO accumulator: debounced switches form a
// target step, and the output step ramps toward it by at most SLEW_STEP per
// slew tick (or follows it directly when ramping is disabled).
module nco_step_ctrl
  import nco_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 SLEW_DIV        = 50000,
  parameter logic [PHASE_W-1:0] SLEW_STEP       = 32'h0004_0000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [SW_W-1:0]    sw,
  input  logic               ramp_en,
  output logic [PHASE_W-1:0] phase_step,
  output logic               step_valid,
  output logic               settled
);

  localparam int            TW        = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SLEW_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam int            PAD_W     = PHASE_W - SW_W - STEP_SHIFT;

  logic [SW_W-1:0]    w_sw_stable;
  logic [PHASE_W-1:0] w_target;
  logic [PHASE_W-1:0] w_diff;
  logic [PHASE_W-1:0] w_step_nxt;
  logic               w_tick;
  slew_state_e        w_state_nxt;

  logic [TW-1:0]      r_tick_cnt;
  slew_state_e        r_state;
  logic [PHASE_W-1:0] r_step;
  logic               r_valid;

  sw_debounce #(
    .WIDTH          (SW_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .i_sw       (sw),
    .o_sw_stable(w_sw_stable)
  );

  // Switch LSB maps to one SLEW_STEP; top bits stay clear so no wrap is possible.
  assign w_target = {{PAD_W{1'b0}}, w_sw_stable, {STEP_SHIFT{1'b0}}};
  assign w_tick   = (r_tick_cnt == TICK_LAST);

  // Free-running slew tick divider, independent of the ramp state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_ONE;
    end
  end

  // Direction from a live compare each cycle, so a target change redirects at once.
  always_comb begin
    w_state_nxt = IDLE;
    w_diff      = '0;
    w_step_nxt  = r_step;
    if (w_target > r_step) begin
      w_state_nxt = UP;
      w_diff      = w_target - r_step;
    end else if (w_target < r_step) begin
      w_state_nxt = DOWN;
      w_diff      = r_step - w_target;
    end
    if (!ramp_en) begin
      w_step_nxt = w_target;
    end else if (w_tick) begin
      case (w_state_nxt)
        UP:      w_step_nxt = (w_diff <= SLEW_STEP) ? w_target : r_step + SLEW_STEP;
        DOWN:    w_step_nxt = (w_diff <= SLEW_STEP) ? w_target : r_step - SLEW_STEP;
        default: w_step_nxt = r_step;
      endcase
    end
  end

  // State, step and change-pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_valid <= (w_step_nxt != r_step);
    end
  end

  assign phase_step = r_step;
  assign step_valid = r_valid;
  assign settled    = (r_state == IDLE);

endmodule

// File: tb/tb_nco_step_ctrl.sv
// Bench for nco_step_ctrl with short debounce/slew settings.
module tb_nco_step_ctrl;

  localparam int          DEB  = 4;
  localparam int          DIV  = 3;
  localparam logic [31:0] STEP = 32'h0004_0000;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [9:0]  sw      = '0;
  logic        ramp_en = 1'b1;
  logic [31:0] phase_step;
  logic        step_valid;
  logic        settled;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  nco_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SLEW_DIV       (DIV),
    .SLEW_STEP      (STEP)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .sw        (sw),
    .ramp_en   (ramp_en),
    .phase_step(phase_step),
    .step_valid(step_valid),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw switches delayed two clocks, a value is accepted
  // once it has been seen DEB+1 clocks in a row, and the step moves toward
  // the target once per DIV-th clock by at most STEP (or jumps when not ramping).
  logic [9:0]  m_d1, m_d2, m_run_val, m_stable;
  int          m_run, m_n;
  logic [31:0] m_step, m_tgt, m_nxt;
  logic        m_valid, m_settled;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d1 = '0; m_d2 = '0; m_run_val = '0; m_run = 1; m_stable = '0;
      m_n = 0; m_step = '0; m_valid = 1'b0; m_settled = 1'b1;
    end else begin
      m_tgt = {4'd0, m_stable, 18'd0};
      m_nxt = m_step;
      if (!ramp_en) m_nxt = m_tgt;
      else if ((m_n % DIV) == DIV - 1) begin
        if (m_tgt > m_step)      m_nxt = (m_tgt - m_step <= STEP) ? m_tgt : m_step + STEP;
        else if (m_tgt < m_step) m_nxt = (m_step - m_tgt <= STEP) ? m_tgt : m_step - STEP;
      end
      m_settled = (m_tgt == m_step);
      m_valid   = (m_nxt != m_step);
      m_step    = m_nxt;
      if (m_d2 == m_run_val) begin
        if (m_run < DEB + 1) m_run++;
      end else begin
        m_run_val = m_d2;
        m_run     = 1;
      end
      if (m_run >= DEB + 1) m_stable = m_run_val;
      m_d2 = m_d1;
      m_d1 = sw;
      m_n++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("phase_step", phase_step, m_step);
    check("step_valid", 32'(step_valid), 32'(m_valid));
    check("settled", 32'(settled), 32'(m_settled));
  end

  always @(negedge clk) if (step_valid === 1'b1) n_pulses++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int hold;
    bit seen;

    // Reset with sw=0, then everything must hold still.
    cyc(3);
    rst_n = 1'b1;
    n_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("rst_hold_step", phase_step, 32'h0);
      check("rst_hold_settled", 32'(settled), 32'h1);
    end
    check("rst_hold_pulses", n_pulses, 0);

    // Ramp 0 -> 3 switch LSBs.
    sw = 10'd3; n_pulses = 0;
    cyc(30);
    check("ramp3_step", phase_step, 32'h000C_0000);
    check("ramp3_settled", 32'(settled), 32'h1);
    check("ramp3_pulses", n_pulses, 3);

    // Short glitch to 1 must be filtered.
    n_pulses = 0;
    sw = 10'd1; cyc(3);
    sw = 10'd3; cyc(20);
    check("glitch_step", phase_step, 32'h000C_0000);
    check("glitch_pulses", n_pulses, 0);

    // Direct follow with ramping disabled.
    ramp_en = 1'b0; n_pulses = 0;
    sw = 10'h3FF; cyc(20);
    check("direct_step", phase_step, 32'h0FFC_0000);
    check("direct_pulses", n_pulses, 1);

    // Reversal mid-ramp: go to 0, ramp toward 8, redirect to 1.
    sw = 10'd0; cyc(20);
    check("rev_base", phase_step, 32'h0);
    ramp_en = 1'b1; sw = 10'd8;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc(1);
      if (phase_step == 32'h0004_0000) seen = 1'b1;
    end
    check("rev_reach_timeout", 32'(seen), 32'h1);
    sw = 10'd1; cyc(40);
    check("rev_final_step", phase_step, 32'h0004_0000);
    check("rev_final_settled", 32'(settled), 32'h1);

    // Asynchronous reset between clock edges during a ramp.
    sw = 10'h3FF; cyc(15);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("arst_step", phase_step, 32'h0);
    check("arst_settled", 32'(settled), 32'h1);
    check("arst_valid", 32'(step_valid), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(7);
    check("arst_redebounce", phase_step, 32'h0);
    cyc(30);
    check("arst_reramp", phase_step, 32'h0028_0000);

    // Randomized traffic checked by the model every cycle.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0:       sw = 10'h3FF;
        1:       sw = 10'h000;
        2:       sw = 10'($urandom_range(0, 15));
        default: sw = 10'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) ramp_en = ~ramp_en;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 40));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      cyc(hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
